// File: rtl/mem_io_pkg.sv
// Shared definitions for the memory/IO responder: FSM states and I/O register map.
package mem_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int         IO_WINDOW = 4;
  localparam logic [1:0] IO_LED    = 2'd0;
  localparam logic [1:0] IO_SW     = 2'd1;
  localparam logic [1:0] IO_TIMER  = 2'd2;
  localparam logic [1:0] IO_STATUS = 2'd3;

endpackage

// File: rtl/io_timer.sv
// Countdown timer register with tick decrement, write-over-tick priority and a
// sticky expiry flag whose set beats a same-cycle clear.
module io_timer #(
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  input  logic              tick_in,
  output logic [DATA_W-1:0] count,
  output logic              expired
);

  logic [DATA_W-1:0] count_q, count_d;
  logic              expired_q, expired_d;
  logic              expire_set;

  always_comb begin
    count_d    = count_q;
    expire_set = 1'b0;
    if (wr_en) begin
      count_d = wr_data;
    end else if (tick_in && (count_q != '0)) begin
      count_d    = count_q - DATA_W'(1);
      expire_set = (count_q == DATA_W'(1));
    end
    expired_d = expired_q;
    if (expire_set) begin
      expired_d = 1'b1;
    end else if (clr) begin
      expired_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= expired_d;
    end
  end

  assign count   = count_q;
  assign expired = expired_q;

endmodule

// File: rtl/mem_io_responder.sv
// Memory/IO responder: block RAM plus LED/SW/TIMER/STATUS registers behind a
// one-outstanding valid/ready request port. MEM_IO_BUS_ERR_EN enables rsp_err decode.
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int              DATA_W      = 16,
  parameter int              ADDR_W      = 16,
  parameter int              RAM_WORDS   = 1024,
  parameter int              WAIT_STATES = 1,
  parameter logic [ADDR_W-1:0] IO_BASE   = 'hFF00
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  input  logic [15:0]       sw_in,
  input  logic              tick_in,
  output logic [15:0]       led_out,
  output logic              timer_expired
);

  localparam int IDX_W = $clog2(RAM_WORDS);

  state_e            state_q, state_d;
  logic [2:0]        wait_q, wait_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [DATA_W-1:0] led_q, led_d;
  logic [15:0]       sw_meta_q, sw_sync_q;
  logic [DATA_W-1:0] mem [RAM_WORDS];

  logic              hs, commit, ram_we;
  logic              eff_we, ram_hit, io_hit;
  logic [ADDR_W-1:0] eff_addr, io_off;
  logic [DATA_W-1:0] eff_wdata, io_rdata, timer_count;
  logic [1:0]        io_sel;
  logic [IDX_W-1:0]  ram_idx;
  logic              timer_wr, status_clr;

  // Handshake: a request transfers on a cycle where req_valid && req_ready; req_ready
  // is high only in IDLE, so at most one request is in flight.
  assign req_ready = (state_q == ST_IDLE);
  assign hs        = req_valid && req_ready;
  assign rsp_valid = (state_q == ST_RESP);

  // The commit edge is the one entering RESP: from IDLE the live request is used,
  // from WAIT the latched copy.
  assign eff_we    = (state_q == ST_IDLE) ? req_we    : we_q;
  assign eff_addr  = (state_q == ST_IDLE) ? req_addr  : addr_q;
  assign eff_wdata = (state_q == ST_IDLE) ? req_wdata : wdata_q;
  assign ram_hit   = 32'(eff_addr) < 32'(RAM_WORDS);
  assign io_off    = eff_addr - IO_BASE;
  assign io_hit    = io_off < ADDR_W'(IO_WINDOW);
  assign io_sel    = io_off[1:0];
  assign ram_idx   = eff_addr[IDX_W-1:0];

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    commit  = 1'b0;
    we_d    = hs ? req_we    : we_q;
    addr_d  = hs ? req_addr  : addr_q;
    wdata_d = hs ? req_wdata : wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          if (ram_hit && (WAIT_STATES > 0)) begin
            state_d = ST_WAIT;
            wait_d  = 3'(WAIT_STATES - 1);
          end else begin
            state_d = ST_RESP;
            commit  = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == 3'd0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    io_rdata = '0;
    case (io_sel)
      IO_LED:    io_rdata = led_q;
      IO_SW:     io_rdata = DATA_W'(sw_sync_q);
      IO_TIMER:  io_rdata = timer_count;
      IO_STATUS: io_rdata = {{(DATA_W-1){1'b0}}, timer_expired};
      default:   io_rdata = '0;
    endcase
  end

  always_comb begin
    rsp_rdata_d = rsp_rdata_q;
    if (commit) begin
      if (eff_we)       rsp_rdata_d = '0;
      else if (ram_hit) rsp_rdata_d = mem[ram_idx];
      else if (io_hit)  rsp_rdata_d = io_rdata;
      else              rsp_rdata_d = '0;
    end
    led_d = led_q;
    if (commit && eff_we && io_hit && (io_sel == IO_LED)) led_d = eff_wdata;
  end

  assign ram_we     = reset && commit && eff_we && ram_hit;
  assign timer_wr   = commit && eff_we && io_hit && (io_sel == IO_TIMER);
  assign status_clr = commit && eff_we && io_hit && (io_sel == IO_STATUS) && eff_wdata[0];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      wait_q      <= 3'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_rdata_q <= '0;
      led_q       <= '0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      led_q       <= led_d;
      sw_meta_q   <= sw_in;
      sw_sync_q   <= sw_meta_q;
    end
  end

  // RAM contents survive reset; only the write strobe is gated by it.
  always_ff @(posedge clock) begin
    if (ram_we) mem[ram_idx] <= eff_wdata;
  end

  io_timer #(.DATA_W(DATA_W)) u_timer (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (timer_wr),
    .wr_data (eff_wdata),
    .clr     (status_clr),
    .tick_in (tick_in),
    .count   (timer_count),
    .expired (timer_expired)
  );

`ifdef MEM_IO_BUS_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (commit) err_d = (!ram_hit && !io_hit) || (io_hit && (io_sel == IO_SW) && eff_we);
  end

  always_ff @(posedge clock) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign rsp_rdata = rsp_rdata_q;
  assign led_out   = led_q[15:0];

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed and random requests, reference model of the
// memory map and timer, scoreboard queue popped by a response monitor.
module tb_mem_io_responder;

  localparam int          RAM_WORDS = 1024;
  localparam int          WS        = 1;
  localparam logic [15:0] IO_BASE   = 16'hFF00;
`ifdef MEM_IO_BUS_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, tick_in = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0, sw_in = '0;
  logic        req_ready, rsp_valid, rsp_err, timer_expired;
  logic [15:0] rsp_rdata, led_out;

  int checks = 0;
  int failures = 0;

  // Scoreboard: {err, rdata}, the monitor cycle the response is due, don't-care data flag
  logic [16:0] exp_q[$];
  int          due_q[$];
  bit          dc_q[$];

  // Reference model state
  int          cyc = 0;
  int          busy_until = 0;
  bit          rst_seen = 0;
  logic [15:0] ram_m [RAM_WORDS];
  bit          known [RAM_WORDS];
  logic [15:0] led_m = '0, timer_m = '0, sw_m1 = '0, sw_m2 = '0;
  logic        exp_m = 1'b0;
  bit          pend_v = 0;
  int          pend_cyc = 0, pend_idx = 0;
  logic [15:0] pend_data = '0;

  mem_io_responder #(.WAIT_STATES(WS)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_err       (rsp_err),
    .sw_in         (sw_in),
    .tick_in       (tick_in),
    .led_out       (led_out),
    .timer_expired (timer_expired)
  );

  // Clock/reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: applies the address-map and timer rules to the inputs seen at each edge.
  always @(posedge clock) begin
    int          old, due, idx;
    logic [15:0] rd, off, tw_data;
    logic        er;
    bit          tw, clr, setx, dc;
    old = cyc;
    cyc = cyc + 1;
    if (!reset) begin
      rst_seen = 1;
      led_m = '0; timer_m = '0; exp_m = 1'b0; sw_m1 = '0; sw_m2 = '0;
      pend_v = 0;
      exp_q.delete(); due_q.delete(); dc_q.delete();
      busy_until = old;
    end else begin
      tw = 0; clr = 0; setx = 0; dc = 0; rd = '0; er = 1'b0; tw_data = '0;
      if (req_valid && old > busy_until) begin
        due = cyc;
        idx = int'(req_addr);
        if (idx < RAM_WORDS) begin
          due = cyc + WS;
          if (req_we) begin
            pend_v = 1; pend_cyc = due; pend_idx = idx; pend_data = req_wdata;
          end else begin
            rd = ram_m[idx];
            dc = !known[idx];
          end
        end else if (req_addr >= IO_BASE && (req_addr - IO_BASE) < 16'd4) begin
          off = req_addr - IO_BASE;
          case (off)
            16'd0: if (req_we) led_m = req_wdata; else rd = led_m;
            16'd1: if (req_we) er = 1'b1; else rd = sw_m2;
            16'd2: if (req_we) begin tw = 1; tw_data = req_wdata; end else rd = timer_m;
            default: if (req_we) clr = req_wdata[0]; else rd = {15'b0, exp_m};
          endcase
        end else begin
          er = 1'b1;
        end
        busy_until = due;
        exp_q.push_back({er & ERR_EN, rd});
        due_q.push_back(due);
        dc_q.push_back(dc);
      end
      if (tw) timer_m = tw_data;
      else if (tick_in && timer_m != 16'd0) begin
        setx = (timer_m == 16'd1);
        timer_m = timer_m - 16'd1;
      end
      if (setx) exp_m = 1'b1;
      else if (clr) exp_m = 1'b0;
      if (pend_v && pend_cyc == cyc) begin
        ram_m[pend_idx] = pend_data;
        known[pend_idx] = 1;
        pend_v = 0;
      end
      sw_m2 = sw_m1;
      sw_m1 = sw_in;
    end
  end

  // Monitor: per-cycle output checks and scoreboard pops on rsp_valid
  always @(negedge clock) begin
    logic [16:0] e;
    int          d;
    bit          x;
    if (rst_seen && reset) begin
      check("req_ready", 32'(req_ready), 32'(cyc > busy_until));
      check("led_out", 32'(led_out), 32'(led_m));
      check("timer_expired", 32'(timer_expired), 32'(exp_m));
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          d = due_q.pop_front();
          x = dc_q.pop_front();
          if (!x) check("rsp_rdata", 32'(rsp_rdata), 32'(e[15:0]));
          check("rsp_err", 32'(rsp_err), 32'(e[16]));
          check("rsp_latency", 32'(cyc), 32'(d));
        end
      end else if (exp_q.size() > 0 && cyc >= due_q[0]) begin
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
        void'(dc_q.pop_front());
      end
    end
  end

  // Driver tasks: all inputs change on the falling edge
  task automatic req(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                     input logic tk);
    int n;
    n = 0;
    @(negedge clock);
    while (!(cyc > busy_until) && n < 50) begin
      req_valid = 1'b0;
      tick_in   = 1'b0;
      @(negedge clock);
      n++;
    end
    if (n >= 50) begin
      checks++;
      failures++;
      $display("FAIL ready_wait: model never ready within 50 cycles (t=%0t)", $time);
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    tick_in   = tk;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      req_valid = 1'b0;
      tick_in   = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    req_valid = 1'b0;
    tick_in   = 1'b1;
  endtask

  function automatic logic [15:0] pick_addr();
    logic [15:0] a;
    case ($urandom_range(0, 5))
      0: a = 16'($urandom_range(0, 15));
      1: a = 16'($urandom_range(0, RAM_WORDS - 1));
      2, 5: a = IO_BASE + 16'($urandom_range(0, 3));
      3: begin
        case ($urandom_range(0, 3))
          0: a = 16'd1023;
          1: a = 16'd1024;
          2: a = 16'hFEFF;
          default: a = 16'hFF04;
        endcase
      end
      default: a = 16'($urandom);
    endcase
    return a;
  endfunction

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_led_out", 32'(led_out), 32'd0);
    check("reset_timer_expired", 32'(timer_expired), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    reset = 1'b1;

    // RAM store then load
    req(1'b1, 16'd5, 16'h1234, 1'b0);
    req(1'b0, 16'd5, 16'h0000, 1'b0);

    // LED write visible the cycle after the handshake
    req(1'b1, IO_BASE, 16'h00A5, 1'b0);
    idle(1);
    check("led_after_write", 32'(led_out), 32'h00A5);

    // Switch synchronizer
    sw_in = 16'hBEEF;
    idle(3);
    req(1'b0, IO_BASE + 16'd1, 16'h0000, 1'b0);

    // Timer countdown to expiry, then hold at zero
    req(1'b1, IO_BASE + 16'd2, 16'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      idle(1);
      req(1'b0, IO_BASE + 16'd2, 16'h0000, 1'b0);
    end
    idle(1);
    check("expired_after_third_tick", 32'(timer_expired), 32'd1);
    tick();
    idle(1);
    req(1'b0, IO_BASE + 16'd2, 16'h0000, 1'b0);

    // Write beats tick; expiry set beats status clear
    req(1'b1, IO_BASE + 16'd2, 16'd5, 1'b1);
    req(1'b0, IO_BASE + 16'd2, 16'h0000, 1'b0);
    req(1'b1, IO_BASE + 16'd2, 16'd1, 1'b0);
    req(1'b1, IO_BASE + 16'd3, 16'd1, 1'b1);
    idle(1);
    check("expired_set_beats_clear", 32'(timer_expired), 32'd1);
    req(1'b1, IO_BASE + 16'd3, 16'd1, 1'b0);
    idle(1);
    check("expired_cleared", 32'(timer_expired), 32'd0);
    req(1'b0, IO_BASE + 16'd3, 16'h0000, 1'b0);

    // Unmapped and boundary addresses
    req(1'b0, 16'h8000, 16'h0000, 1'b0);
    req(1'b1, IO_BASE + 16'd1, 16'h5555, 1'b0);
    req(1'b1, 16'hFF04, 16'h7777, 1'b0);
    req(1'b0, 16'd1024, 16'h0000, 1'b0);
    req(1'b1, 16'd1023, 16'hCAFE, 1'b0);
    req(1'b0, 16'd1023, 16'h0000, 1'b0);
    req(1'b0, 16'hFEFF, 16'h0000, 1'b0);

    // Reset in the middle of a RAM store's wait state
    req(1'b1, 16'd7, 16'h1111, 1'b0);
    req(1'b1, 16'd7, 16'h7777, 1'b0);
    @(negedge clock);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("midreset_req_ready", 32'(req_ready), 32'd1);
    req(1'b0, 16'd7, 16'h0000, 1'b0);

    // Random traffic, ticks and switch changes
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      tick_in = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) sw_in = 16'($urandom);
      req_valid = ($urandom_range(0, 1) == 1);
      req_we    = ($urandom_range(0, 1) == 1);
      req_addr  = pick_addr();
      req_wdata = 16'($urandom);
      if (req_addr == IO_BASE + 16'd2) req_wdata = 16'($urandom_range(0, 6));
    end
    idle(10);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory/IO responder at the far end of the CPU control FSM's load/store and fetch path.
- Accepts one request at a time over a valid/ready handshake.
- Services requests from an internal block RAM or a small register file of memory-mapped game I/O: LEDs, switches and a countdown timer.
- Returns read data, or a write acknowledge, as a single-cycle response pulse.

Parameters:
- DATA_W, 16, data width of requests, responses and I/O registers
- ADDR_W, 16, request address width
- RAM_WORDS, 1024, RAM depth in words; RAM occupies addresses 0..RAM_WORDS-1
- WAIT_STATES, 1, extra cycles a RAM access takes before its response (0..7)
- IO_BASE, 16'hFF00, base address of the I/O register window

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  store data
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  load data; 0 for stores
- rsp_err  out  1  unmapped-address flag, valid with rsp_valid
- sw_in  in  16  raw switch inputs, asynchronous
- tick_in  in  1  one-cycle timer decrement strobe
- led_out  out  16  LED register
- timer_expired  out  1  sticky expiry flag

Behaviour:
- Reset: reset is synchronous and active-low on clock. While reset=0 at a clock edge:
  - state returns to IDLE
  - rsp_valid=0, rsp_rdata=0, rsp_err=0
  - led_out=0, timer=0, timer_expired=0
  - any in-flight request is dropped
  - RAM contents are not cleared
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1 in IDLE only.
  - A handshake (req_valid && req_ready) latches we, addr and wdata.
  - RAM address with WAIT_STATES>0: go to WAIT and load the counter with WAIT_STATES-1.
  - All other cases (RAM with WAIT_STATES=0, I/O, unmapped): go to RESP.
- WAIT: the counter decrements each cycle; at 0, go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, then back to IDLE.
  - The RAM write or I/O write takes effect on entry to RESP.
  - rsp_rdata holds its value until the next response.
- Latency from the handshake cycle N:
  - I/O and unmapped requests: rsp_valid at N+1.
  - RAM requests: rsp_valid at N+1+WAIT_STATES.
- Back-to-back requests: a new request can be accepted no earlier than the cycle after rsp_valid.
- Address map:
  - 0..RAM_WORDS-1: RAM.
  - IO_BASE+0 LED: read/write.
  - IO_BASE+1 SW: read-only, 2-flop synchronized copy of sw_in; writes are ignored.
  - IO_BASE+2 TIMER: read/write.
  - IO_BASE+3 STATUS: bit0 = timer_expired; writing 1 to bit0 clears it; other bits read 0.
  - Everything else is unmapped: reads return 0 and writes are dropped.
- Timer:
  - When tick_in=1 and timer!=0, the timer decrements by 1.
  - A transition from 1 to 0 sets timer_expired.
  - At 0 the timer holds; no wrap.
- Simultaneous events:
  - A TIMER write in the same cycle as tick_in: the write wins and no decrement occurs.
  - Expiry set and a STATUS clear in the same cycle: set wins.
- Widths: RAM index is req_addr[log2(RAM_WORDS)-1:0]; an address must also be < RAM_WORDS to count as a RAM hit.

Optional Feature:
- Macro: MEM_IO_BUS_ERR_EN.
- Defined: rsp_err=1 alongside rsp_valid for unmapped addresses and for writes to SW.
- Undefined: rsp_err is tied to 0 and the error-decode logic is omitted.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package mem_io_pkg:
  - state enum (IDLE/WAIT/RESP)
  - I/O register offsets (LED=0, SW=1, TIMER=2, STATUS=3)
  - I/O window size of 4
- Sub-module io_timer: counter, tick decrement, write-priority rules and sticky expiry flag, with ports clock, reset, wr_en, wr_data, clr, tick_in, count, expired.

Test Plan:
- Reset, then store 16'h1234 to address 5 with WAIT_STATES=1, then load address 5 -> each response arrives 2 cycles after its handshake; load returns rsp_rdata=16'h1234; req_ready=0 in between.
- Store 16'h00A5 to FF00 -> led_out=16'h00A5 the cycle after the handshake. Then drive sw_in=16'hBEEF, wait 3 cycles, load FF01 -> rsp_rdata=16'hBEEF at N+1.
- Store 3 to FF02, then pulse tick_in three times -> timer reads 2, 1, 0; timer_expired rises on the third tick. A fourth tick keeps timer=0.
- Write 5 to TIMER in the same cycle as tick_in -> timer=5. Write STATUS=1 in the same cycle as an expiry -> timer_expired stays 1.
- Load 16'h8000 (unmapped) -> rsp_rdata=0 at N+1. rsp_err=1 with MEM_IO_BUS_ERR_EN defined, 0 without it.
- Assert reset=0 during WAIT of a RAM store -> no rsp_valid; state is IDLE with req_ready=1 after release; the target RAM word is unchanged.
